// File: rtl/a2d_scan_pkg.sv
// a2d_scan_pkg: shared state encoding and widths for the A2D channel scanner.
package a2d_scan_pkg;
  typedef enum logic [2:0] {IDLE, START, GUARD, WAIT_CC, STORE, GAP} state_t;
  localparam int RES_W   = 12;
  localparam int CH_W    = 3;
  localparam int AVG_CNT = 4;
  localparam int AVG_SH  = $clog2(AVG_CNT);
  localparam int ACC_W   = RES_W + AVG_SH;
endpackage

// File: rtl/a2d_res_tbl.sv
// a2d_res_tbl: per-channel result registers, one write port, one async read port.
module a2d_res_tbl
  import a2d_scan_pkg::*;
#(
  parameter int NUM_CH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CH_W-1:0]  wa,
  input  logic [RES_W-1:0] wd,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [RES_W-1:0] rd_data
);
  logic [RES_W-1:0] mem_q [NUM_CH];
  logic [RES_W-1:0] mem_d [NUM_CH];
  always_comb begin
    mem_d = mem_q;
    if (we && int'(wa) < NUM_CH) mem_d[wa] = wd;
  end
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end
  assign rd_data = int'(rd_ch) < NUM_CH ? mem_q[rd_ch] : '0;
endmodule

// File: rtl/a2d_scan.sv
// a2d_scan: round-robin A2D channel scanner with timeout and result table.
// Define A2D_SCAN_AVG_EN to average AVG_CNT back-to-back conversions per channel.
module a2d_scan
  import a2d_scan_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SCAN_GAP = 1000,
  parameter int TMO      = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             strt_cnv,
  output logic [CH_W-1:0]  chnnl,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] res,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [RES_W-1:0] rd_data,
  output logic             scan_done,
  output logic             tmo_err
);
  localparam int CNT_MAX = TMO > SCAN_GAP ? TMO : SCAN_GAP;
  localparam int CW      = $clog2(CNT_MAX + 2);
  state_t           state_q, state_d;
  logic [CH_W-1:0]  chnnl_q, chnnl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tmo_err_q, tmo_err_d;
  logic             tmo_hit_q, tmo_hit_d;
  logic             last_ch;
  logic [RES_W-1:0] wr_data;
  assign last_ch = chnnl_q == CH_W'(NUM_CH - 1);
`ifdef A2D_SCAN_AVG_EN
  logic [AVG_SH-1:0] smp_q, smp_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  assign wr_data = tmo_hit_q ? '0 : RES_W'(acc_q >> AVG_SH);
`else
  assign wr_data = tmo_hit_q ? '0 : res;
`endif
  always_comb begin
    state_d   = state_q;
    chnnl_d   = chnnl_q;
    cnt_d     = cnt_q;
    tmo_err_d = tmo_err_q;
    tmo_hit_d = 1'b0;
`ifdef A2D_SCAN_AVG_EN
    smp_d     = smp_q;
    acc_d     = acc_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = en ? START : IDLE;
        chnnl_d = '0;
      end
      START: state_d = GUARD;
      // cnv_cmplt may still show the previous result here
      GUARD: begin
        state_d = WAIT_CC;
        cnt_d   = '0;
      end
      WAIT_CC: begin
        if (cnv_cmplt) begin
`ifdef A2D_SCAN_AVG_EN
          acc_d   = acc_q + ACC_W'(res);
          smp_d   = smp_q + 1'b1;
          state_d = smp_q == AVG_SH'(AVG_CNT - 1) ? STORE : START;
`else
          state_d = STORE;
`endif
        end else if (cnt_q == CW'(TMO - 1)) begin
          tmo_err_d = 1'b1;
          tmo_hit_d = 1'b1;
          state_d   = STORE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STORE: begin
        cnt_d = '0;
`ifdef A2D_SCAN_AVG_EN
        smp_d = '0;
        acc_d = '0;
`endif
        if (last_ch) begin
          chnnl_d = '0;
          state_d = SCAN_GAP != 0 ? GAP : (en ? START : IDLE);
        end else begin
          chnnl_d = en ? chnnl_q + 1'b1 : '0;
          state_d = en ? START : IDLE;
        end
      end
      GAP: begin
        if (cnt_q == CW'(SCAN_GAP - 1)) state_d = en ? START : IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      chnnl_q   <= '0;
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
      tmo_hit_q <= 1'b0;
`ifdef A2D_SCAN_AVG_EN
      smp_q     <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      chnnl_q   <= chnnl_d;
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
      tmo_hit_q <= tmo_hit_d;
`ifdef A2D_SCAN_AVG_EN
      smp_q     <= smp_d;
      acc_q     <= acc_d;
`endif
    end
  end
  assign strt_cnv  = state_q == START;
  assign scan_done = state_q == STORE && last_ch;
  assign chnnl     = chnnl_q;
  assign tmo_err   = tmo_err_q;
  a2d_res_tbl #(.NUM_CH(NUM_CH)) u_tbl (
    .clk     (clk),
    .rst     (rst),
    .we      (state_q == STORE),
    .wa      (chnnl_q),
    .wd      (wr_data),
    .rd_ch   (rd_ch),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_a2d_scan.sv
// tb_a2d_scan: directed scenarios against an A2D interface model with a strt_cnv scoreboard.
module tb_a2d_scan;
  localparam int NUM_CH   = 8;
  localparam int SCAN_GAP = 20;
  localparam int TMO      = 4095;
  localparam int LAT      = 20;
`ifdef A2D_SCAN_AVG_EN
  localparam int AVG = 4;
`else
  localparam int AVG = 1;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic [2:0]  rd_ch = '0;
  logic [11:0] rd_data;
  logic        scan_done;
  logic        tmo_err;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];
  int epoch = 0;
  bit stale_mode = 0;
  bit drop3 = 0;
  int ofs_tbl[4] = '{0, 1, 2, 4};
  int m_lat, m_stale, m_last, m_idx;
  bit m_busy;

  a2d_scan #(.NUM_CH(NUM_CH), .SCAN_GAP(SCAN_GAP), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .rd_ch(rd_ch), .rd_data(rd_data),
    .scan_done(scan_done), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] expv(input int ch, input int ep);
    return 12'(ch * 100 + ep + (AVG > 1 ? 1 : 0));
  endfunction

  // A2D interface model: clears cnv_cmplt on strt_cnv, completes LAT cycles later
  always @(negedge clk) begin
    if (rst) begin
      cnv_cmplt = 1'b0;
      m_busy = 0;
      m_last = -1;
      m_idx = 0;
      m_stale = 0;
    end else if (strt_cnv) begin
      m_idx = (int'(chnnl) == m_last) ? (m_idx + 1) % 4 : 0;
      m_last = int'(chnnl);
      m_busy = 1;
      m_lat = LAT;
      m_stale = stale_mode ? 2 : 0;
      if (!stale_mode) cnv_cmplt = 1'b0;
    end else if (m_busy) begin
      if (m_stale > 0) begin
        m_stale--;
        if (m_stale == 0) cnv_cmplt = 1'b0;
      end
      if (m_lat > 0) m_lat--;
      if (m_lat == 0 && m_stale == 0 && !(drop3 && m_last == 3)) begin
        cnv_cmplt = 1'b1;
        res = 12'(m_last * 100 + epoch + (AVG > 1 ? ofs_tbl[m_idx] : 0));
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && strt_cnv) begin
      chk("strt_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("strt_chnnl", 32'(chnnl), exp_q.pop_front());
    end
  end

  task automatic push_ch(input int ch, input int n);
    repeat (n) exp_q.push_back(ch);
  endtask

  task automatic push_scan(input int last);
    for (int c = 0; c <= last; c++) push_ch(c, AVG);
  endtask

  task automatic chk_tbl(input int ch, input logic [11:0] e);
    rd_ch = 3'(ch);
    #1;
    chk($sformatf("tbl%0d", ch), 32'(rd_data), 32'(e));
  endtask

  task automatic wait_strt(input int ch, input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(strt_cnv && int'(chnnl) == ch) && k < bound);
    chk($sformatf("wait_strt_ch%0d", ch), 32'(strt_cnv && int'(chnnl) == ch), 1);
  endtask

  task automatic wait_sd(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!scan_done && k < bound);
    chk("wait_scan_done", 32'(scan_done), 1);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_strt", 32'(strt_cnv), 0);
    chk("rst_chnnl", 32'(chnnl), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_tmo_err", 32'(tmo_err), 0);
    for (int c = 0; c < NUM_CH; c++) chk_tbl(c, 12'h000);
    rst = 1'b0;
    // scan 1 (epoch 0) then scan 2 (epoch 7) dropped during channel 2
    push_scan(7);
    push_scan(2);
    rd_ch = 3'd7;
    en = 1'b1;
    wait_sd(3000);
    #1;
    chk("rd_old_on_write", 32'(rd_data), 0);
    epoch = 7;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("scan_done_pulse", 32'(scan_done), 0);
        #1;
        chk("rd_new_ch7", 32'(rd_data), 32'(expv(7, 0)));
      end
    end while (!strt_cnv && k < 200);
    chk("gap_len", k, SCAN_GAP + 1);
    wait_strt(2, 1000);
    en = 1'b0;
    repeat (200) @(negedge clk);
    chk("q_empty_en_drop", exp_q.size(), 0);
    for (int c = 0; c < 3; c++) chk_tbl(c, expv(c, 7));
    for (int c = 3; c < NUM_CH; c++) chk_tbl(c, expv(c, 0));
    chk_tbl(5, 12'(500 + (AVG > 1 ? 1 : 0)));
    chk("tmo_err_clear", 32'(tmo_err), 0);
    // stale cnv_cmplt held through START/GUARD
    stale_mode = 1;
    epoch = 3;
    push_ch(0, AVG);
    en = 1'b1;
    wait_strt(0, 50);
    en = 1'b0;
    repeat (200) @(negedge clk);
    stale_mode = 0;
    chk("q_empty_stale", exp_q.size(), 0);
    chk_tbl(0, expv(0, 3));
    // timeout on channel 3
    drop3 = 1;
    epoch = 9;
    push_scan(2);
    push_ch(3, 1);
    for (int c = 4; c < NUM_CH; c++) push_ch(c, AVG);
    en = 1'b1;
    wait_strt(3, 2000);
    k = 0;
    while (!tmo_err && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", k, TMO + 2);
    wait_sd(2000);
    en = 1'b0;
    drop3 = 0;
    repeat (40) @(negedge clk);
    chk("q_empty_tmo", exp_q.size(), 0);
    chk("tmo_err_sticky", 32'(tmo_err), 1);
    chk_tbl(2, expv(2, 9));
    chk_tbl(3, 12'h000);
    chk_tbl(4, expv(4, 9));
    chk_tbl(7, expv(7, 9));
    // reset during WAIT_CC of channel 1
    epoch = 11;
    push_ch(0, AVG);
    push_ch(1, AVG);
    en = 1'b1;
    wait_strt(1, 500);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strt", 32'(strt_cnv), 0);
    chk("mid_rst_chnnl", 32'(chnnl), 0);
    chk("mid_rst_scan_done", 32'(scan_done), 0);
    chk("mid_rst_tmo_err", 32'(tmo_err), 0);
    for (int c = 0; c < NUM_CH; c++) chk_tbl(c, 12'h000);
    exp_q.delete();
    @(negedge clk);
    push_ch(0, AVG);
    rst = 1'b0;
    wait_strt(0, 50);
    en = 1'b0;
    repeat (200) @(negedge clk);
    chk("q_empty_rst", exp_q.size(), 0);
    chk_tbl(0, expv(0, 11));
    chk_tbl(1, 12'h000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
